// File: rtl/elbeth_load_store_unit_pkg.sv
// Shared definitions for the ELBETH load/store unit: access sizes, op-field
// bit positions, FSM state encodings and the alignment rule.
package elbeth_load_store_unit_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  localparam int LSU_OP_STORE    = 3;
  localparam int LSU_OP_UNSIGNED = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10,
    ST_EXC  = 2'b11
  } lsu_state_e;

  // Size 11 is handled as a word, so anything that is not byte/half needs
  // both low address bits clear.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    case (size)
      LSU_SIZE_B: return 1'b0;
      LSU_SIZE_H: return addr_lo[0];
      default:    return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/elbeth_lsu_align.sv
// Combinational lane logic: misalign detection, store byte-lane replication
// and enables, and load lane select with sign/zero extension.
module elbeth_lsu_align
  import elbeth_load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_src,
  input  logic [31:0] ld_src,
  output logic        misaligned,
  output logic [31:0] st_data,
  output logic [3:0]  st_wsel,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_src[{addr_lo, 3'b000} +: 8];
  assign ld_half = addr_lo[1] ? ld_src[31:16] : ld_src[15:0];

  // Lane steering per access size; the unsigned bit only matters for sub-word loads.
  always_comb begin
    misaligned = lsu_misaligned(size, addr_lo);
    st_data    = st_src;
    st_wsel    = 4'b1111;
    ld_data    = ld_src;
    case (size)
      LSU_SIZE_B: begin
        st_data = {4{st_src[7:0]}};
        st_wsel = 4'b0001 << addr_lo;
        ld_data = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      LSU_SIZE_H: begin
        st_data = {2{st_src[15:0]}};
        st_wsel = 4'b0011 << {addr_lo[1], 1'b0};
        ld_data = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        st_data = st_src;
        st_wsel = 4'b1111;
        ld_data = ld_src;
      end
    endcase
  end

endmodule

// File: rtl/elbeth_load_store_unit.sv
// ELBETH memory-access stage: issues one data-memory access per request,
// stalls upstream until it completes, and turns misalignment or a bus
// timeout into a single-cycle exception pulse.
//
// state | meaning
// IDLE  | waiting for a request; misaligned requests go straight to EXC
// WAIT  | dmem_en held, waiting for dmem_ready or the timeout
// RESP  | rsp_valid pulse with the aligned load data
// EXC   | exc_misaligned or exc_bus_error pulse with the faulting address
module elbeth_load_store_unit
  import elbeth_load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wsel,
  output logic        dmem_en,
  output logic        dmem_wr,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        lsu_stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        exc_misaligned,
  output logic        exc_bus_error,
  output logic [31:0] exc_addr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter is loaded on entry to WAIT; reaching zero without ready is the timeout.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wsel_q, wsel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       exc_addr_q, exc_addr_d;

  logic              in_idle, in_wait;
  logic [1:0]        al_size, al_addr_lo;
  logic              al_unsigned, al_misaligned;
  logic [31:0]       al_st_data, al_ld_data;
  logic [3:0]        al_st_wsel;

  assign in_idle = (state_q == ST_IDLE);
  assign in_wait = (state_q == ST_WAIT);

  // The single aligner sees the live request in IDLE (store lanes, misalign)
  // and the registered request afterwards (load lane select).
  assign al_size     = in_idle ? req_op[1:0] : op_q[1:0];
  assign al_unsigned = in_idle ? req_op[LSU_OP_UNSIGNED] : op_q[LSU_OP_UNSIGNED];
  assign al_addr_lo  = in_idle ? req_addr[1:0] : addr_q[1:0];

  elbeth_lsu_align u_align (
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .addr_lo     (al_addr_lo),
    .st_src      (req_wdata),
    .ld_src      (dmem_rdata),
    .misaligned  (al_misaligned),
    .st_data     (al_st_data),
    .st_wsel     (al_st_wsel),
    .ld_data     (al_ld_data)
  );

  // Next-state and register updates for the access sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wsel_d     = wsel_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    bus_err_d  = bus_err_q;
    exc_addr_d = exc_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (al_misaligned) begin
            exc_addr_d = req_addr;
            bus_err_d  = 1'b0;
            state_d    = ST_EXC;
          end else begin
            op_d    = req_op;
            addr_d  = req_addr;
            wdata_d = req_op[LSU_OP_STORE] ? al_st_data : 32'h0;
            wsel_d  = req_op[LSU_OP_STORE] ? al_st_wsel : 4'b0000;
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          rdata_d = op_q[LSU_OP_STORE] ? 32'h0 : al_ld_data;
          state_d = ST_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == '0)) begin
          bus_err_d  = 1'b1;
          exc_addr_d = addr_q;
          state_d    = ST_EXC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state, with synchronous reset forcing IDLE and clearing every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wsel_q     <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wsel_q     <= wsel_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign dmem_en        = in_wait;
  assign dmem_wr        = in_wait & op_q[LSU_OP_STORE];
  assign dmem_addr      = {addr_q[31:2], 2'b00};
  assign dmem_wdata     = wdata_q;
  assign dmem_wsel      = in_wait ? wsel_q : 4'b0000;
  assign lsu_stall      = (in_idle & req_valid) | in_wait;
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_rdata      = rdata_q;
  assign exc_misaligned = (state_q == ST_EXC) & ~bus_err_q;
  assign exc_bus_error  = (state_q == ST_EXC) & bus_err_q;
  assign exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_elbeth_load_store_unit.sv
// Directed bench for the ELBETH load/store unit, built with a 4-cycle timeout.
module tb_elbeth_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wsel;
  logic        dmem_en;
  logic        dmem_wr;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        lsu_stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        exc_misaligned;
  logic        exc_bus_error;
  logic [31:0] exc_addr;

  int checks = 0;
  int errors = 0;

  elbeth_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wsel      (dmem_wsel),
    .dmem_en        (dmem_en),
    .dmem_wr        (dmem_wr),
    .dmem_rdata     (dmem_rdata),
    .dmem_ready     (dmem_ready),
    .lsu_stall      (lsu_stall),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .exc_misaligned (exc_misaligned),
    .exc_bus_error  (exc_bus_error),
    .exc_addr       (exc_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request for one edge (edge N); returns at cycle N+1, 1ns after the edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Full access with ready in N+1; samples the response cycle N+2.
  task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            output logic got_valid, output logic [31:0] got_rdata);
    issue(op, addr, wd);
    dmem_ready = 1'b1;
    dmem_rdata = rd;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    @(negedge clk);
    got_valid = rsp_valid;
    got_rdata = rsp_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    dmem_rdata = 32'h0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dmem_en, dmem_wr, lsu_stall, rsp_valid, exc_misaligned, exc_bus_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {dmem_en, dmem_wr, lsu_stall, rsp_valid, exc_misaligned, exc_bus_error});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, dmem_wsel, rsp_rdata, exc_addr} !== 132'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {dmem_addr, dmem_wdata, dmem_wsel, rsp_rdata, exc_addr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_word_store_load();
    logic        v;
    logic [31:0] d;
    issue(4'b1010, 32'h100, 32'hDEADBEEF);
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({dmem_en, dmem_wr, lsu_stall, dmem_wsel} !== 7'b111_1111) begin
      errors++;
      $display("FAIL word_store_ctrl: got %b expected 1111111", {dmem_en, dmem_wr, lsu_stall, dmem_wsel});
    end
    checks++;
    if (dmem_addr !== 32'h100 || dmem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_store_bus: got addr %h data %h expected 00000100 deadbeef", dmem_addr, dmem_wdata);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, lsu_stall, dmem_en} !== 3'b100 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL word_store_rsp: got v/stall/en %b rdata %h expected 100 00000000",
               {rsp_valid, lsu_stall, dmem_en}, rsp_rdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_pulse_width: got %b expected 0", rsp_valid);
    end
    @(posedge clk); #1;
    run_access(4'b0010, 32'h100, 32'h0, 32'hDEADBEEF, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_load: got v %b rdata %h expected 1 deadbeef", v, d);
    end
  endtask

  task automatic test_sub_word();
    logic        v;
    logic [31:0] d;
    run_access(4'b0000, 32'h103, 32'h0, 32'h80FF_0000, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_signed: got v %b rdata %h expected 1 ffffff80", v, d);
    end
    run_access(4'b0100, 32'h103, 32'h0, 32'h80FF_0000, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h00000080) begin
      errors++;
      $display("FAIL lb_unsigned: got v %b rdata %h expected 1 00000080", v, d);
    end
    run_access(4'b0001, 32'h102, 32'h0, 32'h80FF_0000, v, d);
    checks++;
    if (d !== 32'hFFFF80FF) begin
      errors++;
      $display("FAIL lh_signed: got %h expected ffff80ff", d);
    end
    run_access(4'b0101, 32'h100, 32'h0, 32'h1234_F00D, v, d);
    checks++;
    if (d !== 32'h0000F00D) begin
      errors++;
      $display("FAIL lhu_low: got %h expected 0000f00d", d);
    end
    run_access(4'b0110, 32'h108, 32'h0, 32'h8000_0001, v, d);
    checks++;
    if (d !== 32'h80000001) begin
      errors++;
      $display("FAIL lw_unsigned_ignored: got %h expected 80000001", d);
    end
    issue(4'b1000, 32'h102, 32'h0000_00AB);
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem_wdata !== 32'hABABABAB || dmem_wsel !== 4'b0100 || dmem_addr !== 32'h100) begin
      errors++;
      $display("FAIL sb_lanes: got wdata %h wsel %b addr %h expected abababab 0100 00000100",
               dmem_wdata, dmem_wsel, dmem_addr);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    issue(4'b1001, 32'h102, 32'h5555_1234);
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem_wdata !== 32'h12341234 || dmem_wsel !== 4'b1100) begin
      errors++;
      $display("FAIL sh_lanes: got wdata %h wsel %b expected 12341234 1100", dmem_wdata, dmem_wsel);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    logic [3:0]  ops   [2] = '{4'b0010, 4'b1001};
    logic [31:0] addrs [2] = '{32'h102, 32'h101};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], addrs[i], 32'h0);
      @(negedge clk);
      checks++;
      if ({exc_misaligned, exc_bus_error, dmem_en, rsp_valid, lsu_stall} !== 5'b10000) begin
        errors++;
        $display("FAIL misaligned_flags[%0d]: got %b expected 10000", i,
                 {exc_misaligned, exc_bus_error, dmem_en, rsp_valid, lsu_stall});
      end
      checks++;
      if (exc_addr !== addrs[i]) begin
        errors++;
        $display("FAIL misaligned_addr[%0d]: got %h expected %h", i, exc_addr, addrs[i]);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({exc_misaligned, dmem_en, rsp_valid} !== 3'b000) begin
        errors++;
        $display("FAIL misaligned_after[%0d]: got %b expected 000", i, {exc_misaligned, dmem_en, rsp_valid});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    issue(4'b0010, 32'h200, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (dmem_en !== 1'b1 || exc_bus_error !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait[N+%0d]: got en %b berr %b expected 1 0", k, dmem_en, exc_bus_error);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({exc_bus_error, exc_misaligned, lsu_stall, dmem_en, rsp_valid} !== 5'b10000) begin
      errors++;
      $display("FAIL timeout_fire: got %b expected 10000",
               {exc_bus_error, exc_misaligned, lsu_stall, dmem_en, rsp_valid});
    end
    checks++;
    if (exc_addr !== 32'h200) begin
      errors++;
      $display("FAIL timeout_addr: got %h expected 00000200", exc_addr);
    end
    @(posedge clk); #1;
    issue(4'b0010, 32'h204, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11223344;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, exc_bus_error} !== 2'b10 || rsp_rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL ready_beats_timeout: got v/berr %b rdata %h expected 10 11223344",
               {rsp_valid, exc_bus_error}, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    logic        v;
    logic [31:0] d;
    issue(4'b0010, 32'h300, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dmem_en, lsu_stall, rsp_valid, exc_bus_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_wait: got %b expected 0000", {dmem_en, lsu_stall, rsp_valid, exc_bus_error});
    end
    @(posedge clk); #1;
    run_access(4'b0010, 32'h304, 32'h0, 32'hCAFEF00D, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL after_reset_access: got v %b rdata %h expected 1 cafef00d", v, d);
    end
  endtask

  task automatic test_back_to_back();
    issue(4'b1010, 32'h400, 32'h55AA55AA);
    req_addr  = 32'h7FC;
    req_wdata = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) dmem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (dmem_addr !== 32'h400 || dmem_wdata !== 32'h55AA55AA || dmem_en !== 1'b1) begin
        errors++;
        $display("FAIL wait_stable[N+%0d]: got addr %h data %h en %b expected 00000400 55aa55aa 1",
                 k, dmem_addr, dmem_wdata, dmem_en);
      end
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    req_valid  = 1'b1;
    req_op     = 4'b0010;
    req_addr   = 32'h500;
    @(negedge clk);
    checks++;
    if ({rsp_valid, lsu_stall, dmem_en} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_resp: got v/stall/en %b expected 100", {rsp_valid, lsu_stall, dmem_en});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({lsu_stall, dmem_en} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_idle_stall: got stall/en %b expected 10", {lsu_stall, dmem_en});
    end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem_en !== 1'b1 || dmem_addr !== 32'h500) begin
      errors++;
      $display("FAIL b2b_second: got en %b addr %h expected 1 00000500", dmem_en, dmem_addr);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_sub_word();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
